// File: rtl/cart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cart_pkg : shared mapper modes, mirroring and write-FSM state encoding     |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package cart_pkg;

  localparam int MODE_NROM  = 0;
  localparam int MODE_CNROM = 1;
  localparam int MODE_UNROM = 2;
  localparam int MODE_GXROM = 3;

  localparam int MIRROR_VERT  = 0;
  localparam int MIRROR_HORIZ = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/cart_wr_commit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cart_wr_commit : one register commit per CPU write access                  |
// | Optional CART_BUS_CONFLICT_EN: commit data is ANDed with the ROM byte.     |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module cart_wr_commit
  import cart_pkg::*;
#(
  parameter int MODE = MODE_CNROM
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        i_wr,
  input  logic [7:0]  i_data,
  input  logic [14:0] i_addr,
  input  logic [7:0]  i_rom_d,
  output logic        o_commit,
  output logic [7:0]  o_data,
  output logic        o_cap_active,
  output logic [14:0] o_cap_addr
);

  localparam bit c_wr_en = (MODE != MODE_NROM);

  logic      r_wr_d;
  logic      w_rise;
  wr_state_t r_state;
  wr_state_t w_state_nxt;

  // r_wr_d resets high so a write held through reset release is not an edge
  assign w_rise = c_wr_en && i_wr && !r_wr_d;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_wr_d  <= 1'b1;
      r_state <= ST_IDLE;
    end else begin
      r_wr_d  <= i_wr;
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
`ifdef CART_BUS_CONFLICT_EN
          w_state_nxt = ST_WAIT;
`else
          w_state_nxt = ST_HOLD;
          o_commit    = 1'b1;
`endif
        end
      end
      ST_WAIT: begin
        o_commit    = 1'b1;
        w_state_nxt = i_wr ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (!i_wr) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef CART_BUS_CONFLICT_EN
  logic [7:0]  r_cap_d;
  logic [14:0] r_cap_a;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_cap_d <= 8'h00;
      r_cap_a <= 15'h0000;
    end else if (r_state == ST_IDLE && w_rise) begin
      r_cap_d <= i_data;
      r_cap_a <= i_addr;
    end
  end

  // WAIT re-presents the captured address so the ROM byte matches the write
  assign o_data       = r_cap_d & i_rom_d;
  assign o_cap_active = (r_state == ST_WAIT);
  assign o_cap_addr   = r_cap_a;
`else
  logic w_unused;
  assign w_unused     = ^i_rom_d;
  assign o_data       = i_data;
  assign o_cap_active = 1'b0;
  assign o_cap_addr   = i_addr;
`endif

endmodule
`default_nettype wire

// File: rtl/cart_discrete.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cart_discrete : NROM / CNROM / UNROM / GxROM discrete-logic mapper         |
// | Optional CART_BUS_CONFLICT_EN enables bus-conflict emulation.              |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module cart_discrete
  import cart_pkg::*;
#(
  parameter int MODE       = MODE_CNROM,
  parameter int PRG_BANK_W = 3,
  parameter int CHR_BANK_W = 2,
  parameter int MIRROR     = MIRROR_VERT
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  output logic                    rst_out,
  input  logic                    prg_nce_in,
  input  logic [14:0]             prg_a_in,
  input  logic                    prg_r_nw_in,
  input  logic [7:0]              prg_d_in,
  output logic [7:0]              prg_d_out,
  output logic [PRG_BANK_W+13:0]  prg_rom_a,
  input  logic [7:0]              prg_rom_d,
  input  logic [13:0]             chr_a_in,
  input  logic                    chr_r_nw_in,
  input  logic [7:0]              chr_d_in,
  output logic [7:0]              chr_d_out,
  output logic [CHR_BANK_W+12:0]  chr_rom_a,
  input  logic [7:0]              chr_rom_d,
  output logic                    chr_ram_we,
  output logic                    ciram_nce_out,
  output logic                    ciram_a10_out
);

  logic                   w_wr;
  logic                   w_commit;
  logic                   w_cap_active;
  logic [7:0]             w_cdata;
  logic [14:0]            w_cap_addr;
  logic [14:0]            w_cpu_a;
  logic [PRG_BANK_W-1:0]  r_prg_bank;
  logic [PRG_BANK_W-1:0]  w_prg_load;
  logic [CHR_BANK_W-1:0]  r_chr_bank;
  logic [CHR_BANK_W-1:0]  w_chr_load;
  logic [PRG_BANK_W+7:0]  w_d_prg_ext;
  logic [PRG_BANK_W+7:0]  w_gx_prg_ext;
  logic [CHR_BANK_W+7:0]  w_d_chr_ext;
  logic [CHR_BANK_W+7:0]  w_gx_chr_ext;
  logic [PRG_BANK_W+14:0] w_a_ext;
  logic                   w_unused;

  assign rst_out = ~rst_n;
  assign w_wr    = ~prg_nce_in & ~prg_r_nw_in;

  cart_wr_commit #(
    .MODE (MODE)
  ) u_wr_commit (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .i_wr         (w_wr),
    .i_data       (prg_d_in),
    .i_addr       (prg_a_in),
    .i_rom_d      (prg_rom_d),
    .o_commit     (w_commit),
    .o_data       (w_cdata),
    .o_cap_active (w_cap_active),
    .o_cap_addr   (w_cap_addr)
  );

  assign w_cpu_a = w_cap_active ? w_cap_addr : prg_a_in;

  // Zero-extended views keep field slicing legal for any bank width
  assign w_d_prg_ext  = {{PRG_BANK_W{1'b0}}, w_cdata};
  assign w_gx_prg_ext = {{PRG_BANK_W{1'b0}}, 5'b00000, w_cdata[5:4], 1'b0};
  assign w_d_chr_ext  = {{CHR_BANK_W{1'b0}}, w_cdata};
  assign w_gx_chr_ext = {{CHR_BANK_W{1'b0}}, 6'b000000, w_cdata[1:0]};
  assign w_a_ext      = {{PRG_BANK_W{1'b0}}, w_cpu_a};

  if (MODE == MODE_UNROM) begin : g_unrom
    assign w_prg_load = w_d_prg_ext[PRG_BANK_W-1:0];
    assign w_chr_load = '0;
    assign prg_rom_a  = w_cpu_a[14] ? {{PRG_BANK_W{1'b1}}, w_cpu_a[13:0]}
                                    : {r_prg_bank, w_cpu_a[13:0]};
  end else if (MODE == MODE_GXROM) begin : g_gxrom
    assign w_prg_load = w_gx_prg_ext[PRG_BANK_W-1:0];
    assign w_chr_load = w_gx_chr_ext[CHR_BANK_W-1:0];
    assign prg_rom_a  = {r_prg_bank[PRG_BANK_W-1:1], w_cpu_a};
  end else if (MODE == MODE_CNROM) begin : g_cnrom
    assign w_prg_load = '0;
    assign w_chr_load = w_d_chr_ext[CHR_BANK_W-1:0];
    assign prg_rom_a  = w_a_ext[PRG_BANK_W+13:0];
  end else begin : g_nrom
    assign w_prg_load = '0;
    assign w_chr_load = '0;
    assign prg_rom_a  = w_a_ext[PRG_BANK_W+13:0];
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      r_prg_bank <= '0;
      r_chr_bank <= '0;
    end else if (w_commit) begin
      r_prg_bank <= w_prg_load;
      r_chr_bank <= w_chr_load;
    end
  end

  assign chr_rom_a     = {r_chr_bank, chr_a_in[12:0]};
  assign chr_ram_we    = (MODE == MODE_UNROM) && !chr_r_nw_in && !chr_a_in[13];
  assign prg_d_out     = prg_nce_in  ? 8'h00 : prg_rom_d;
  assign chr_d_out     = chr_a_in[13] ? 8'h00 : chr_rom_d;
  assign ciram_nce_out = ~chr_a_in[13];
  assign ciram_a10_out = (MIRROR == MIRROR_HORIZ) ? chr_a_in[11] : chr_a_in[10];

  assign w_unused = ^{chr_d_in, r_prg_bank, w_d_prg_ext, w_gx_prg_ext,
                      w_d_chr_ext, w_gx_chr_ext, w_a_ext};

endmodule
`default_nettype wire
